// File: rtl/reg_mem_xfer.sv
// Register file plus word memory with a small command FSM: immediate load, register-to-memory
// store, memory-to-register load and a side-effect-free memory read.
module reg_mem_xfer #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned NREG    = 8,
    parameter int unsigned MEM_LAT = 1,
    localparam int unsigned REG_W  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clka,
    input  logic              rstn,
    input  logic              start,
    input  logic [1:0]        opcode,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] address,
    input  logic [REG_W-1:0]  regNo,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [1:0] OpLoadi = 2'd0;
    localparam logic [1:0] OpStore = 2'd1;
    localparam logic [1:0] OpLoad  = 2'd2;
    localparam logic [REG_W:0] NregLim = (REG_W + 1)'(NREG);
    localparam logic [2:0] LatInit = 3'(MEM_LAT);

    typedef enum logic [1:0] {StIdle, StExec, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [REG_W-1:0]    reg_q, reg_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                err_q, err_d;
    logic                reg_we;
    logic [DATA_W-1:0]   reg_wdata;
    logic                mem_we;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   mem_q [Depth];

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            op_q     <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            reg_q    <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            reg_q    <= reg_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[reg_q] <= reg_wdata;
        end
    end

    // Memory is deliberately not reset; an aborted STORE never reaches EXEC under reset.
    always_ff @(posedge clka) begin
        if (mem_we) begin
            mem_q[addr_q] <= regs_q[reg_q];
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        addr_d    = addr_q;
        reg_d     = reg_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        result_d  = result_q;
        err_d     = 1'b0;
        reg_we    = 1'b0;
        reg_wdata = data_q;
        mem_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if ({1'b0, regNo} >= NregLim) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = opcode;
                        data_d  = data_in;
                        addr_d  = address;
                        reg_d   = regNo;
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                if (op_q == OpLoadi) begin
                    reg_we   = 1'b1;
                    result_d = data_q;
                    state_d  = StDone;
                end else if (op_q == OpStore) begin
                    mem_we   = 1'b1;
                    result_d = regs_q[reg_q];
                    state_d  = StDone;
                end else begin
                    rd_d    = mem_q[addr_q];
                    cnt_d   = LatInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    result_d = rd_q;
                    if (op_q == OpLoad) begin
                        reg_we    = 1'b1;
                        reg_wdata = rd_q;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy   = (state_q == StExec) || (state_q == StWait);
    assign done   = (state_q == StDone);
    assign err    = err_q;
    assign result = result_q;

endmodule
